// File: rtl/serial_word_receiver.sv
// Deserialises a synchronised sclk/sdata/slatch stream into WIDTH-bit words.
// Emits a one-cycle valid on a complete frame, or frame_err on a short one.
module serial_word_receiver #(
    parameter int WIDTH       = 16,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           sclk,
    input  logic                           sdata,
    input  logic                           slatch,
    output logic [WIDTH-1:0]               data_out,
    output logic                           valid,
    output logic                           frame_err,
    output logic [$clog2(WIDTH+1)-1:0]     bit_cnt,
    output logic [1:0]                     state_dbg
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0] LAST_C  = CW'(WIDTH - 1);
    localparam int GW = $clog2(SYNC_STAGES + 2);
    localparam logic [GW-1:0] GUARD_END = GW'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sclk_sync, sdata_sync, slatch_sync;
    logic                   sclk_d, slatch_d;
    logic                   sclk_rise_q, slatch_rise_q, sdata_q;
    logic [GW-1:0]          guard_cnt;
    logic                   edges_live;
    logic [WIDTH-1:0]       sr, sr_n, sr_shifted, data_n;
    logic [CW-1:0]          cnt_n;
    logic                   valid_n, err_n, shift_en, latch_en;

    assign edges_live = (guard_cnt == GUARD_END);

    // Edge strobes are registered so sdata_q stays aligned with sclk_rise_q;
    // the guard hides the chain filling up right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync     <= '0;
            sdata_sync    <= '0;
            slatch_sync   <= '0;
            sclk_d        <= 1'b0;
            slatch_d      <= 1'b0;
            sclk_rise_q   <= 1'b0;
            slatch_rise_q <= 1'b0;
            sdata_q       <= 1'b0;
            guard_cnt     <= '0;
        end else begin
            sclk_sync     <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            sdata_sync    <= {sdata_sync[SYNC_STAGES-2:0], sdata};
            slatch_sync   <= {slatch_sync[SYNC_STAGES-2:0], slatch};
            sclk_d        <= sclk_sync[SYNC_STAGES-1];
            slatch_d      <= slatch_sync[SYNC_STAGES-1];
            sclk_rise_q   <= edges_live & sclk_sync[SYNC_STAGES-1] & ~sclk_d;
            slatch_rise_q <= edges_live & slatch_sync[SYNC_STAGES-1] & ~slatch_d;
            sdata_q       <= sdata_sync[SYNC_STAGES-1];
            if (!edges_live) guard_cnt <= guard_cnt + GW'(1);
        end
    end

    generate
        if (WIDTH == 1) begin : g_w1
            assign sr_shifted = sdata_q;
        end else if (MSB_FIRST) begin : g_msb
            assign sr_shifted = {sr[WIDTH-2:0], sdata_q};
        end else begin : g_lsb
            assign sr_shifted = {sdata_q, sr[WIDTH-1:1]};
        end
    endgenerate

    assign shift_en = en & sclk_rise_q;
    assign latch_en = en & slatch_rise_q;

    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = bit_cnt;
        data_n  = data_out;
        valid_n = 1'b0;
        err_n   = 1'b0;
        if (shift_en) begin
            sr_n = sr_shifted;
            if (bit_cnt != WIDTH_C) cnt_n = bit_cnt + CW'(1);
            case (state)
                IDLE:    state_n = (WIDTH == 1) ? FULL : RECV;
                RECV:    state_n = (bit_cnt == LAST_C) ? FULL : RECV;
                FULL:    state_n = FULL;
                default: state_n = IDLE;
            endcase
        end
        // A latch in the same cycle as a shift judges the frame including that bit.
        if (latch_en) begin
            if (cnt_n == WIDTH_C) begin
                data_n  = sr_n;
                valid_n = 1'b1;
            end else begin
                err_n = 1'b1;
            end
            sr_n    = '0;
            cnt_n   = '0;
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            bit_cnt   <= cnt_n;
            data_out  <= data_n;
            valid     <= valid_n;
            frame_err <= err_n;
        end
    end

    assign state_dbg = state;
endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: one MSB-first and one LSB-first instance share the pins,
// checked every cycle against a frame-level model of received bits.
module tb_serial_word_receiver;
    localparam int W = 16;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic sclk = 1'b0, sdata = 1'b0, slatch = 1'b0;
    logic [W-1:0] data_m, data_l;
    logic valid_m, valid_l, err_m, err_l;
    logic [4:0] cnt_m, cnt_l;
    logic [1:0] st_m, st_l;

    serial_word_receiver #(.WIDTH(W), .MSB_FIRST(1'b1), .SYNC_STAGES(S)) dut_m (
        .clk(clk), .rst(rst), .en(en), .sclk(sclk), .sdata(sdata), .slatch(slatch),
        .data_out(data_m), .valid(valid_m), .frame_err(err_m), .bit_cnt(cnt_m), .state_dbg(st_m)
    );
    serial_word_receiver #(.WIDTH(W), .MSB_FIRST(1'b0), .SYNC_STAGES(S)) dut_l (
        .clk(clk), .rst(rst), .en(en), .sclk(sclk), .sdata(sdata), .slatch(slatch),
        .data_out(data_l), .valid(valid_l), .frame_err(err_l), .bit_cnt(cnt_l), .state_dbg(st_l)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk = 1'b0;

    typedef struct {
        int         at;
        int         cnt;
        bit         v;
        bit         e;
        logic [W-1:0] dm;
        logic [W-1:0] dl;
    } ev_t;
    ev_t exp_q[$];

    // model state on the driver side (frame bits, words last captured)
    bit m_bits[$];
    logic [W-1:0] m_dm = '0, m_dl = '0;
    // model state as it should appear on the outputs this cycle
    int cur_cnt = 0;
    logic [W-1:0] cur_dm = '0, cur_dl = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // scoreboard: one compare per output per cycle
    always @(posedge clk) begin
        bit ev_v, ev_e;
        cyc++;
        #1;
        if (chk) begin
            ev_v = 1'b0;
            ev_e = 1'b0;
            while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                if (exp_q[0].at < cyc) check("stale_event", cyc, exp_q[0].at);
                cur_cnt = exp_q[0].cnt;
                cur_dm  = exp_q[0].dm;
                cur_dl  = exp_q[0].dl;
                ev_v    = exp_q[0].v;
                ev_e    = exp_q[0].e;
                void'(exp_q.pop_front());
            end
            check("valid_m", valid_m, ev_v);
            check("valid_l", valid_l, ev_v);
            check("frame_err_m", err_m, ev_e);
            check("frame_err_l", err_l, ev_e);
            check("data_out_m", data_m, cur_dm);
            check("data_out_l", data_l, cur_dl);
            check("bit_cnt_m", cnt_m, cur_cnt);
            check("bit_cnt_l", cnt_l, cur_cnt);
        end
    end

    // model: a pin rise driven now is first sampled at cyc+1 and acted on S+1 edges later
    task automatic model_edge(input bit do_shift, input bit do_latch, input bit b);
        ev_t ev;
        int base;
        if (!en) return;
        ev.v = 1'b0;
        ev.e = 1'b0;
        if (do_shift) begin
            m_bits.push_back(b);
            if (m_bits.size() > W) void'(m_bits.pop_front());
        end
        if (do_latch) begin
            if (m_bits.size() == W) begin
                base = 0;
                for (int i = 0; i < W; i++) begin
                    m_dm[W-1-i] = m_bits[base+i];
                    m_dl[i]     = m_bits[base+i];
                end
                ev.v = 1'b1;
            end else begin
                ev.e = 1'b1;
            end
            m_bits.delete();
        end
        ev.at  = cyc + S + 2;
        ev.cnt = m_bits.size();
        ev.dm  = m_dm;
        ev.dl  = m_dl;
        exp_q.push_back(ev);
    endtask

    // driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit b);
        @(negedge clk);
        sdata = b;
        wait_cyc(3);
        sclk = 1'b1;
        model_edge(1'b1, 1'b0, b);
        wait_cyc(3);
        sclk = 1'b0;
        wait_cyc(3);
    endtask

    task automatic latch();
        @(negedge clk);
        slatch = 1'b1;
        model_edge(1'b0, 1'b1, 1'b0);
        wait_cyc(3);
        slatch = 1'b0;
        wait_cyc(4);
    endtask

    task automatic pulse_and_latch(input bit b);
        @(negedge clk);
        sdata = b;
        wait_cyc(3);
        sclk   = 1'b1;
        slatch = 1'b1;
        model_edge(1'b1, 1'b1, b);
        wait_cyc(3);
        sclk   = 1'b0;
        slatch = 1'b0;
        wait_cyc(4);
    endtask

    task automatic send_bits(input logic [31:0] val, input int n, input bit msb);
        logic [31:0] v;
        v = val;
        for (int i = 0; i < n; i++) pulse(msb ? v[n-1-i] : v[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        chk    = 1'b0;
        sclk   = 1'b0;
        sdata  = 1'b0;
        slatch = 1'b0;
        wait_cyc(2);
        check("rst_data_m", data_m, 0);
        check("rst_data_l", data_l, 0);
        check("rst_valid", {valid_m, valid_l}, 0);
        check("rst_err", {err_m, err_l}, 0);
        check("rst_cnt", {cnt_m, cnt_l}, 0);
        exp_q.delete();
        m_bits.delete();
        m_dm = '0; m_dl = '0;
        cur_cnt = 0; cur_dm = '0; cur_dl = '0;
        rst = 1'b0;
        wait_cyc(S + 3);
        chk = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        do_reset();

        // 1: MSB-first word
        send_bits(32'hA5C3, 16, 1'b1);
        latch();
        check("t1_word_m", data_m, 16'hA5C3);
        check("t1_word_l", data_l, 16'hC3A5);
        check("t1_cnt", cnt_m, 0);

        // 2: LSB-first word
        send_bits(32'h1234, 16, 1'b0);
        latch();
        check("t2_word_l", data_l, 16'h1234);
        check("t2_word_m", data_m, 16'h2C48);

        // 3: short frame keeps prior word
        for (int i = 0; i < 10; i++) pulse(1'($urandom_range(0, 1)));
        latch();
        check("t3_keep_l", data_l, 16'h1234);
        check("t3_keep_m", data_m, 16'h2C48);

        // 3b: empty frame
        latch();

        // 4: overlong frame keeps the last 16 bits
        send_bits(32'hF0005, 20, 1'b1);
        check("t4_cnt_sat", cnt_m, 16);
        latch();
        check("t4_word_m", data_m, 16'h0005);

        // 5: last bit and latch together
        for (int i = 0; i < 15; i++) pulse(1'($urandom_range(0, 1)));
        pulse_and_latch(1'b1);
        check("t5_lsb_bit", data_m[0], 1'b1);
        check("t5_msb_bit_l", data_l[15], 1'b1);

        // 6: enable gating, then reset mid-frame
        for (int i = 0; i < 6; i++) pulse(1'b1);
        en = 1'b0;
        for (int i = 0; i < 4; i++) pulse(1'b0);
        check("t6_frozen", cnt_m, 6);
        en = 1'b1;
        pulse(1'b0);
        pulse(1'b1);
        check("t6_cnt8", cnt_m, 8);
        do_reset();
        send_bits(32'hBEEF, 16, 1'b1);
        latch();
        check("t6_word_m", data_m, 16'hBEEF);

        // random frames with occasional disabled pulses
        for (int f = 0; f < 30; f++) begin
            len = $urandom_range(0, 20);
            for (int i = 0; i < len; i++) begin
                en = ($urandom_range(0, 7) != 0);
                pulse(1'($urandom_range(0, 1)));
            end
            en = 1'b1;
            if (len > 0 && $urandom_range(0, 1) == 1) pulse_and_latch(1'($urandom_range(0, 1)));
            else latch();
        end
        wait_cyc(8);
        check("end_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
